// File: rtl/ddr_sched_pkg.sv
// Shared types and default parameters for the DDR ring scheduler.
// Holds the FSM encoding, the direction constants and the level width.
package ddr_sched_pkg;

  localparam int DEF_DEPTH    = 1048576;
  localparam int DEF_QUOTA    = 16;
  localparam int DEF_OB_LIMIT = 125;
  localparam int DEF_GAP      = 4;
  localparam int LVL_W        = 21;

  typedef enum logic [2:0] {
    S_CAL,
    S_IDLE,
    S_WR,
    S_RD,
    S_GAP
  } state_t;

  typedef enum logic {
    DIR_WR,
    DIR_RD
  } dir_t;

endpackage

// File: rtl/burst_level_cnt.sv
// Ring fill level in DDR bursts, saturating at 0 and DEPTH.
// Sticky flags record writes into a full ring and reads from an empty one.
module burst_level_cnt
  import ddr_sched_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_udf
);

  localparam logic [LVL_W-1:0] TOP = LVL_W'(DEPTH);

  logic up;
  logic dn;

  assign up    = inc & ~dec;
  assign dn    = dec & ~inc;
  assign full  = (level == TOP);
  assign empty = (level == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      level   <= '0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      unique case (1'b1)
        up: begin
          if (full) err_ovf <= 1'b1;
          else      level   <= level + 1'b1;
        end
        dn: begin
          if (empty) err_udf <= 1'b1;
          else       level   <= level - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ddr_ring_sched.sv
// Arbitrates DDR write/read permission for a ring buffer.
// Quota-based alternation with a settle gap between directions.
module ddr_ring_sched
  import ddr_sched_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int QUOTA    = DEF_QUOTA,
  parameter int OB_LIMIT = DEF_OB_LIMIT,
  parameter int GAP      = DEF_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             calib_done,
  input  logic             capture_en,
  input  logic [7:0]       ib_count,
  input  logic [6:0]       ob_count,
  input  logic             wr_done,
  input  logic             rd_done,
  output logic             writes_en,
  output logic             reads_en,
  output logic [LVL_W-1:0] level,
  output logic             ring_full,
  output logic             ring_empty,
  output logic             err_ovf,
  output logic             err_udf
);

  localparam logic [31:0]      QUOTA_U = 32'(QUOTA);
  localparam logic [31:0]      GAP_U   = 32'(GAP);
  localparam logic [31:0]      OBL_U   = 32'(OB_LIMIT);
  localparam logic [LVL_W-1:0] TOP_M1  = LVL_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] ONE     = LVL_W'(1);

  state_t      state;
  state_t      state_n;
  dir_t        last_dir;
  logic [31:0] quota_cnt;
  logic [31:0] gap_cnt;

  logic we_ok;
  logic re_ok;
  logic wr_fill;
  logic rd_drain;
  logic wr_quota;
  logic rd_quota;
  logic pick_wr;
  logic pick_rd;

  burst_level_cnt #(
    .DEPTH(DEPTH)
  ) u_level (
    .clk     (clk),
    .reset   (reset),
    .inc     (wr_done),
    .dec     (rd_done),
    .level   (level),
    .full    (ring_full),
    .empty   (ring_empty),
    .err_ovf (err_ovf),
    .err_udf (err_udf)
  );

  assign we_ok = capture_en & (ib_count != '0) & ~ring_full;
  assign re_ok = ~ring_empty & ({25'd0, ob_count} < OBL_U);

  // Drop the enable on the pulse that fills or drains the ring,
  // so the DDR side never sees permission one burst too long.
  assign wr_fill  = wr_done & ~rd_done & (level == TOP_M1);
  assign rd_drain = rd_done & ~wr_done & (level == ONE);

  assign wr_quota = (quota_cnt + 32'(wr_done)) >= QUOTA_U;
  assign rd_quota = (quota_cnt + 32'(rd_done)) >= QUOTA_U;

  assign pick_wr = we_ok & (~re_ok | (last_dir == DIR_RD));
  assign pick_rd = re_ok & (~we_ok | (last_dir == DIR_WR));

  always_comb begin
    state_n = state;
    unique case (state)
      S_CAL: begin
        if (calib_done) state_n = S_IDLE;
      end
      S_IDLE: begin
        unique case (1'b1)
          pick_wr: state_n = S_WR;
          pick_rd: state_n = S_RD;
          default: ;
        endcase
      end
      S_WR: begin
        if (!we_ok || wr_fill || (wr_quota && re_ok))
          state_n = S_GAP;
      end
      S_RD: begin
        if (!re_ok || rd_drain || (rd_quota && we_ok))
          state_n = S_GAP;
      end
      S_GAP: begin
        if ((gap_cnt + 32'd1) >= GAP_U) state_n = S_IDLE;
      end
      default: state_n = S_CAL;
    endcase
    if (!calib_done) state_n = S_CAL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_CAL;
      writes_en <= 1'b0;
      reads_en  <= 1'b0;
      quota_cnt <= '0;
      gap_cnt   <= '0;
      last_dir  <= DIR_RD;
    end else begin
      state     <= state_n;
      writes_en <= (state_n == S_WR);
      reads_en  <= (state_n == S_RD);
      if (state == S_IDLE && state_n == S_WR) begin
        quota_cnt <= '0;
        last_dir  <= DIR_WR;
      end else if (state == S_IDLE && state_n == S_RD) begin
        quota_cnt <= '0;
        last_dir  <= DIR_RD;
      end else if ((state == S_WR && wr_done) ||
                   (state == S_RD && rd_done)) begin
        quota_cnt <= quota_cnt + 32'd1;
      end
      if (state != S_GAP) gap_cnt <= '0;
      else                gap_cnt <= gap_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_ddr_ring_sched.sv
// Bench for ddr_ring_sched: a large-ring and an 8-burst-ring instance
// checked every cycle against an ownership/level model.
module tb_ddr_ring_sched;

  localparam int QUOTA = 16;
  localparam int GAP   = 4;
  localparam int OBL   = 125;
  localparam int DEP_A = 1048576;
  localparam int DEP_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst[2];
  logic        cal[2];
  logic        cap[2];
  logic        wd[2];
  logic        rd[2];
  logic [7:0]  ib[2];
  logic [6:0]  ob[2];
  logic        we[2];
  logic        re[2];
  logic        full[2];
  logic        empty[2];
  logic        ovf[2];
  logic        udf[2];
  logic [20:0] lvl[2];

  bit auto_w[2];
  bit auto_r[2];
  bit frc_w[2];
  bit frc_r[2];

  int checks = 0;
  int errors = 0;

  // model: owner 0=none 1=write 2=read, last 1=write 2=read
  int m_lvl[2];
  int m_own[2];
  int m_gap[2];
  int m_cnt[2];
  int m_last[2];
  bit m_cal[2];
  bit m_ovf[2];
  bit m_udf[2];
  int depth[2] = '{DEP_A, DEP_B};

  ddr_ring_sched u_a (
    .clk(clk), .reset(rst[0]), .calib_done(cal[0]),
    .capture_en(cap[0]), .ib_count(ib[0]), .ob_count(ob[0]),
    .wr_done(wd[0]), .rd_done(rd[0]),
    .writes_en(we[0]), .reads_en(re[0]), .level(lvl[0]),
    .ring_full(full[0]), .ring_empty(empty[0]),
    .err_ovf(ovf[0]), .err_udf(udf[0])
  );

  ddr_ring_sched #(.DEPTH(DEP_B)) u_b (
    .clk(clk), .reset(rst[1]), .calib_done(cal[1]),
    .capture_en(cap[1]), .ib_count(ib[1]), .ob_count(ob[1]),
    .wr_done(wd[1]), .rd_done(rd[1]),
    .writes_en(we[1]), .reads_en(re[1]), .level(lvl[1]),
    .ring_full(full[1]), .ring_empty(empty[1]),
    .err_ovf(ovf[1]), .err_udf(udf[1])
  );

  task automatic check(input string name, input int inst,
                       input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d got %0d want %0d", name, inst, act, exp);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_lvl[i] = 0; m_own[i] = 0; m_gap[i] = 0; m_cnt[i] = 0;
        m_last[i] = 2; m_cal[i] = 0; m_ovf[i] = 0; m_udf[i] = 0;
      end else begin
        bit up, dn, weok, reok;
        int nl;
        up   = wd[i] && !rd[i];
        dn   = rd[i] && !wd[i];
        weok = cap[i] && ib[i] != 0 && m_lvl[i] != depth[i];
        reok = m_lvl[i] != 0 && int'(ob[i]) < OBL;
        nl   = m_lvl[i];
        if (up) begin
          if (nl == depth[i]) m_ovf[i] = 1; else nl++;
        end
        if (dn) begin
          if (nl == 0) m_udf[i] = 1; else nl--;
        end
        if (!cal[i]) begin
          m_cal[i] = 0; m_own[i] = 0; m_gap[i] = 0;
        end else if (!m_cal[i]) begin
          m_cal[i] = 1;
        end else if (m_gap[i] > 0) begin
          m_gap[i]--;
        end else if (m_own[i] == 0) begin
          if (weok && (!reok || m_last[i] == 2)) begin
            m_own[i] = 1; m_last[i] = 1; m_cnt[i] = 0;
          end else if (reok) begin
            m_own[i] = 2; m_last[i] = 2; m_cnt[i] = 0;
          end
        end else if (m_own[i] == 1) begin
          if (wd[i]) m_cnt[i]++;
          if (!weok || nl == depth[i] || (m_cnt[i] >= QUOTA && reok)) begin
            m_own[i] = 0; m_gap[i] = GAP;
          end
        end else begin
          if (rd[i]) m_cnt[i]++;
          if (!reok || nl == 0 || (m_cnt[i] >= QUOTA && weok)) begin
            m_own[i] = 0; m_gap[i] = GAP;
          end
        end
        m_lvl[i] = nl;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check("writes_en", i, we[i], m_own[i] == 1);
      check("reads_en", i, re[i], m_own[i] == 2);
      check("level", i, lvl[i], m_lvl[i]);
      check("ring_full", i, full[i], m_lvl[i] == depth[i]);
      check("ring_empty", i, empty[i], m_lvl[i] == 0);
      check("err_ovf", i, ovf[i], m_ovf[i]);
      check("err_udf", i, udf[i], m_udf[i]);
    end
  endtask

  // drive at negedge, model and compare just after the posedge
  task automatic step();
    for (int i = 0; i < 2; i++) begin
      wd[i] = frc_w[i] | (auto_w[i] & we[i]);
      rd[i] = frc_r[i] | (auto_r[i] & re[i]);
    end
    @(posedge clk);
    model_update();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic run_len(input int i, input bit wr, input int bound,
                         output int n);
    n = 0;
    while ((wr ? we[i] : re[i]) && n < bound) begin
      n++;
      step();
    end
  endtask

  task automatic low_len(input int i, input int bound, output int n);
    n = 0;
    while (!we[i] && !re[i] && n < bound) begin
      n++;
      step();
    end
  endtask

  task automatic wait_en(input int i, input bit wr, input int bound);
    for (int k = 0; k < bound; k++) begin
      if (wr ? we[i] : re[i]) break;
      step();
    end
  endtask

  initial begin
    int n;
    int hi;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1; cal[i] = 0; cap[i] = 0; ib[i] = 0; ob[i] = 0;
      wd[i] = 0; rd[i] = 0;
      auto_w[i] = 0; auto_r[i] = 0; frc_w[i] = 0; frc_r[i] = 0;
    end
    @(negedge clk);
    step();
    step();
    for (int i = 0; i < 2; i++) begin
      check("rst_level", i, lvl[i], 0);
      check("rst_empty", i, empty[i], 1);
      check("rst_full", i, full[i], 0);
      check("rst_we", i, we[i], 0);
      check("rst_re", i, re[i], 0);
    end
    rst[0] = 0; rst[1] = 0;

    // calibration gating while 40 bursts are preloaded
    cap[0] = 1; ib[0] = 10; frc_w[0] = 1; hi = 0;
    for (int k = 0; k < 100; k++) begin
      if (k == 40) frc_w[0] = 0;
      step();
      if (we[0]) hi++;
    end
    check("cal_gate_we", 0, hi, 0);
    check("preload_lvl", 0, lvl[0], 40);

    // quota alternation
    ib[0] = 50; ob[0] = 0; cal[0] = 1;
    auto_w[0] = 1; auto_r[0] = 1;
    step();
    step();
    check("cal_rise_we", 0, we[0], 1);
    run_len(0, 1, 100, n);
    check("wr_quota", 0, n, 16);
    low_len(0, 100, n);
    check("gap_len", 0, n, GAP + 1);
    check("tie_to_rd", 0, re[0], 1);
    run_len(0, 0, 100, n);
    check("rd_quota", 0, n, 16);
    low_len(0, 100, n);
    check("gap_len2", 0, n, GAP + 1);
    check("back_to_wr", 0, we[0], 1);
    check("lvl_cycle", 0, lvl[0], 40);

    // reads blocked: quota must not end the write burst
    ob[0] = 7'd125;
    run_len(0, 1, 40, n);
    check("no_quota_exit", 0, n, 40);
    cap[0] = 0; auto_w[0] = 0; auto_r[0] = 0;
    for (int k = 0; k < 8; k++) step();
    check("ob_block_re", 0, re[0], 0);
    check("cap_off_we", 0, we[0], 0);
    cal[0] = 0;

    // full boundary on the 8-burst ring
    ob[1] = 7'd125; cap[1] = 1; ib[1] = 10; cal[1] = 1; auto_w[1] = 1;
    wait_en(1, 1, 5);
    check("b_wr_grant", 1, we[1], 1);
    run_len(1, 1, 20, n);
    check("fill_pulses", 1, n, 8);
    check("fill_full", 1, full[1], 1);
    check("fill_lvl", 1, lvl[1], 8);
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (we[1] || re[1]) hi++;
    end
    check("full_idle", 1, hi, 0);
    auto_w[1] = 0; cap[1] = 0;
    frc_w[1] = 1; step(); frc_w[1] = 0;
    check("ovf_lvl", 1, lvl[1], 8);
    check("ovf_flag", 1, ovf[1], 1);

    // simultaneous pulses then underflow
    frc_r[1] = 1;
    for (int k = 0; k < 3; k++) step();
    frc_w[1] = 1; step(); frc_w[1] = 0;
    check("both_lvl", 1, lvl[1], 5);
    for (int k = 0; k < 5; k++) step();
    check("udf_pre", 1, udf[1], 0);
    step(); frc_r[1] = 0;
    check("udf_lvl", 1, lvl[1], 0);
    check("udf_flag", 1, udf[1], 1);

    // drain with capture stopped
    frc_w[1] = 1;
    for (int k = 0; k < 3; k++) step();
    frc_w[1] = 0;
    check("drain_pre", 1, lvl[1], 3);
    ob[1] = 0; auto_r[1] = 1;
    wait_en(1, 0, 5);
    check("drain_grant", 1, re[1], 1);
    run_len(1, 0, 20, n);
    check("drain_pulses", 1, n, 3);
    check("drain_empty", 1, empty[1], 1);
    check("drain_re", 1, re[1], 0);
    auto_r[1] = 0;

    // reset in the middle of a write grant
    ob[1] = 7'd125; cap[1] = 1;
    wait_en(1, 1, 12);
    check("rst_pre_grant", 1, we[1], 1);
    frc_w[1] = 1;
    for (int k = 0; k < 7; k++) step();
    check("rst_pre_lvl", 1, lvl[1], 7);
    check("rst_pre_we", 1, we[1], 1);
    rst[1] = 1;
    step();
    rst[1] = 0; frc_w[1] = 0;
    check("rst_mid_we", 1, we[1], 0);
    check("rst_mid_lvl", 1, lvl[1], 0);
    check("rst_mid_ovf", 1, ovf[1], 0);
    step();
    check("rst_cal_we", 1, we[1], 0);
    step();
    check("rst_regrant", 1, we[1], 1);
    cal[1] = 0;
    step();
    check("cal_drop_we", 1, we[1], 0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_ring_sched.md
DDR_RING_SCHED -- requirements
Module: ddr_ring_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 1048576, meaning the ring capacity in DDR bursts of 256 bits.
REQ-002 SHALL have parameter QUOTA, default 16, meaning the maximum consecutive bursts granted to one direction while the other direction is eligible.
REQ-003 SHALL have parameter OB_LIMIT, default 125, meaning reads are eligible only while ob_count < OB_LIMIT.
REQ-004 SHALL have parameter GAP, default 4, meaning the settle cycles after dropping an enable before re-arbitration.
REQ-005 Ports, listed as name, direction, width, meaning:
- clk, in, 1, single clock.
- reset, in, 1, synchronous active-high reset.
- calib_done, in, 1, DDR calibration complete.
- capture_en, in, 1, acquisition running.
- ib_count, in, 8, input FIFO fill level.
- ob_count, in, 7, output FIFO fill level.
- wr_done, in, 1, one-cycle pulse per accepted DDR write command.
- rd_done, in, 1, one-cycle pulse per accepted DDR read command.
- writes_en, out, 1, write permission to the DDR interface.
- reads_en, out, 1, read permission to the DDR interface.
- level, out, 21, bursts currently stored.
- ring_full, out, 1, level == DEPTH.
- ring_empty, out, 1, level == 0.
- err_ovf, out, 1, sticky flag: write accepted while full.
- err_udf, out, 1, sticky flag: read accepted while empty.

Function
REQ-006 States SHALL be S_CAL, S_IDLE, S_WR, S_RD, S_GAP.
REQ-007 S_CAL SHALL go to S_IDLE on the first cycle calib_done=1. calib_done falling from any state SHALL force S_CAL and drop both enables next cycle.
REQ-008 Eligibility:
- we_ok = capture_en & (ib_count≥1) & !ring_full.
- re_ok = !ring_empty & (ob_count<OB_LIMIT).
REQ-009 In S_IDLE, if only one of we_ok/re_ok is set, that direction SHALL be granted. If both are set, the direction opposite last_dir SHALL be granted. last_dir resets to READ, so the first tie goes to WRITE.
REQ-010 A grant SHALL register the enable (writes_en or reads_en) one cycle after the decision, clear the quota counter, and update last_dir.
REQ-011 writes_en and reads_en SHALL never both be 1 in the same cycle.
REQ-012 S_WR exits to S_GAP when either condition holds:
- !we_ok;
- the quota counter reaches QUOTA while re_ok=1.
Quota counts wr_done pulses. S_RD is symmetric with rd_done and we_ok.
REQ-013 With the other direction not eligible, the quota SHALL NOT force an exit.
REQ-014 S_GAP SHALL hold both enables at 0 for GAP cycles, then return to S_IDLE.
REQ-015 level SHALL update every cycle in every state:
- +1 on wr_done alone;
- −1 on rd_done alone;
- unchanged when both or neither pulse.
REQ-016 wr_done alone at level==DEPTH SHALL leave level at DEPTH (saturate) and set err_ovf. rd_done alone at level==0 SHALL leave level at 0 and set err_udf.
REQ-017 ring_full and ring_empty SHALL be combinational from level, with no added latency.
REQ-018 capture_en falling SHALL NOT clear level, so reads drain the stored data.

Reset
REQ-019 On reset:
- state = S_CAL;
- writes_en = 0 and reads_en = 0;
- level = 0, so ring_empty = 1 and ring_full = 0;
- err_ovf = 0 and err_udf = 0;
- quota counter = 0, gap counter = 0, last_dir = READ.
REQ-020 Reset asserted mid-grant SHALL deassert the enables on the next edge. Pulses on wr_done/rd_done coincident with reset SHALL be ignored.

Structure
REQ-021 The state encoding, direction constants and the default parameter values SHALL reside in the shared package ddr_sched_pkg.
REQ-022 The level up/down counter, with its saturation and error flags, SHALL be a separate sub-module named burst_level_cnt. Arbitration logic SHALL stay in the top module.

Verification
REQ-023 Calibration gating: calib_done=0 for 100 cycles with capture_en=1 and ib_count=10 -> writes_en stays 0. After calib_done rises -> writes_en=1 within 2 cycles.
REQ-024 Quota alternation (QUOTA=16): both directions eligible (level=40, ib_count=50, ob_count=0), ack every done pulse -> exactly 16 wr_done under writes_en, then 4 gap cycles, then reads_en for 16 rd_done; the pattern repeats.
REQ-025 Full boundary (DEPTH=8): 8 wr_done -> ring_full=1, writes_en=0 after S_GAP. A forced 9th wr_done -> level stays 8 and err_ovf=1.
REQ-026 Simultaneous pulses: at level=5, wr_done and rd_done in the same cycle -> level=5. Then rd_done alone at level=0 -> level=0 and err_udf=1.
REQ-027 Drain and output back-pressure: capture_en=0 with level=3 -> reads_en=1 until 3 rd_done, then ring_empty=1 and reads_en=0. Separately, ob_count=125 -> reads_en stays 0.
REQ-028 Reset mid-operation: reset asserted while in S_WR with level=7 -> next cycle writes_en=0, level=0, state=S_CAL.
